// File: rtl/dff_ms_pkg.sv
// Shared constants and types for the master-slave D flip-flop slice.
// Optional clock-enable build: define DFF_MS_CLKEN_EN.
`timescale 1ns/1ps
package dff_ms_pkg;

    // Default number of independent stored bits.
    localparam int DFF_MS_WIDTH_DEFAULT = 1;

    // Power-up / reset value of Q (0 or all-ones across WIDTH).
    localparam logic RESET_Q_DEFAULT = 1'b0;

    // Data vector at the default width.
    typedef logic [DFF_MS_WIDTH_DEFAULT-1:0] dff_ms_data_t;

endpackage

// File: rtl/d_flipflop_master_slave_if.sv
// Panel-side bundle for the master-slave flip-flop: push-button data in,
// LED pair out. The enable button exists only when DFF_MS_CLKEN_EN is defined.
`timescale 1ns/1ps
interface d_flipflop_master_slave_if
    import dff_ms_pkg::*;
#(
    parameter int WIDTH = DFF_MS_WIDTH_DEFAULT
);
    logic [WIDTH-1:0] input_push_button2_d_2;
`ifdef DFF_MS_CLKEN_EN
    logic             input_push_button3_en_5;
`endif
    logic [WIDTH-1:0] output_led1_q_0_3;
    logic [WIDTH-1:0] output_led2_q_0_4;

`ifdef DFF_MS_CLKEN_EN
    // Panel / stimulus side: drives data and enable, observes the LEDs.
    modport master (
        output input_push_button2_d_2,
        output input_push_button3_en_5,
        input  output_led1_q_0_3,
        input  output_led2_q_0_4
    );

    // Flip-flop side.
    modport slave (
        input  input_push_button2_d_2,
        input  input_push_button3_en_5,
        output output_led1_q_0_3,
        output output_led2_q_0_4
    );
`else
    // Panel / stimulus side: drives data, observes the LEDs.
    modport master (
        output input_push_button2_d_2,
        input  output_led1_q_0_3,
        input  output_led2_q_0_4
    );

    // Flip-flop side.
    modport slave (
        input  input_push_button2_d_2,
        output output_led1_q_0_3,
        output output_led2_q_0_4
    );
`endif

endinterface

// File: rtl/d_flipflop_master_slave_latch.sv
// Level-sensitive D latch with asynchronous, dominant reset.
// Transparent while gate is high, holds while gate is low.
`timescale 1ns/1ps
module d_latch_gated #(
    parameter int WIDTH = 1
) (
    input  logic             gate,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset forces rst_val at any gate level; otherwise follow d while open.
    always_latch begin
        if (rst) begin
            q <= rst_val;
        end else if (gate) begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_flipflop_master_slave.sv
// Positive-edge D flip-flop built from a master latch (open while clk=0)
// feeding a slave latch (open while clk=1). Q follows D sampled at the rising
// edge; Qbar is the plain inversion of Q, including during reset.
// Optional build macro DFF_MS_CLKEN_EN adds a clock enable: with enable low
// the master recirculates the slave output so Q holds across edges.
`timescale 1ns/1ps
module d_flipflop_master_slave
    import dff_ms_pkg::*;
#(
    parameter int               WIDTH   = DFF_MS_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_Q = {WIDTH{RESET_Q_DEFAULT}}
) (
    input  logic                             input_clock1_clk_1,
    input  logic                             input_reset_rst_0,
    d_flipflop_master_slave_if.slave         bus
);

    logic             clk_n;
    logic [WIDTH-1:0] master_d;
    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] slave_q;

    assign clk_n = ~input_clock1_clk_1;

`ifdef DFF_MS_CLKEN_EN
    // Enable low: master reloads the slave's value, so the next edge is a no-op.
    assign master_d = bus.input_push_button3_en_5 ? bus.input_push_button2_d_2 : slave_q;
`else
    assign master_d = bus.input_push_button2_d_2;
`endif

    // Master tracks D during the low phase and freezes it at the rising edge.
    d_latch_gated #(
        .WIDTH (WIDTH)
    ) u_master (
        .gate    (clk_n),
        .rst     (input_reset_rst_0),
        .rst_val (RESET_Q),
        .d       (master_d),
        .q       (master_q)
    );

    // Slave passes the frozen master value during the high phase only.
    d_latch_gated #(
        .WIDTH (WIDTH)
    ) u_slave (
        .gate    (input_clock1_clk_1),
        .rst     (input_reset_rst_0),
        .rst_val (RESET_Q),
        .d       (master_q),
        .q       (slave_q)
    );

    assign bus.output_led1_q_0_3 = slave_q;

    // Each Qbar bit is an independent inverter on its own Q bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_qbar
            assign bus.output_led2_q_0_4[gi] = ~slave_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_d_flipflop_master_slave.sv
// Directed + randomized bench for d_flipflop_master_slave.
// Reference model: Q is the D present at the most recent rising edge taken
// outside reset (gated by enable when DFF_MS_CLKEN_EN is defined), else RESET_Q.
`timescale 1ns/1ps
module tb_d_flipflop_master_slave;
    import dff_ms_pkg::*;

    localparam int         W  = 4;
    localparam logic [W-1:0] RQ = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] model_q;

    d_flipflop_master_slave_if #(.WIDTH(W)) bus ();

    d_flipflop_master_slave #(
        .WIDTH   (W),
        .RESET_Q (RQ)
    ) dut (
        .input_clock1_clk_1 (clk),
        .input_reset_rst_0  (rst),
        .bus                (bus)
    );

    // 100 ns period, rising edges at 50, 150, 250 ...
    always #50 clk = ~clk;

    // Compare both LEDs against the model value.
    task automatic check(input string tag, input logic [W-1:0] exp_q);
        vectors++;
        assert (bus.output_led1_q_0_3 === exp_q) else begin
            miscompares++;
            $error("FAIL %s q: observed %h expected %h", tag, bus.output_led1_q_0_3, exp_q);
        end
        vectors++;
        assert (bus.output_led2_q_0_4 === ~exp_q) else begin
            miscompares++;
            $error("FAIL %s qbar: observed %h expected %h", tag, bus.output_led2_q_0_4, ~exp_q);
        end
    endtask

    // Drive D (and enable) mid low phase, take one rising edge, check 10 ns later.
    task automatic edge_step(input logic [W-1:0] d, input logic en, input string tag);
        @(negedge clk);
        #10;
        bus.input_push_button2_d_2 = d;
`ifdef DFF_MS_CLKEN_EN
        bus.input_push_button3_en_5 = en;
`endif
        @(posedge clk);
        if (rst) begin
            model_q = RQ;
        end else begin
`ifdef DFF_MS_CLKEN_EN
            if (en) model_q = d;
`else
            if (en || !en) model_q = d;
`endif
        end
        #10;
        check(tag, model_q);
        $display("[%0t] %s d=%h en=%0d rst=%0d q=%h qbar=%h", $time, tag, d, en, rst,
                 bus.output_led1_q_0_3, bus.output_led2_q_0_4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] caps [4];
        caps[0] = '0; caps[1] = '1; caps[2] = '0; caps[3] = '1;

        bus.input_push_button2_d_2 = '1;
`ifdef DFF_MS_CLKEN_EN
        bus.input_push_button3_en_5 = 1'b1;
`endif
        model_q = RQ;

        // Reset held from time zero: outputs forced, clock and D ignored.
        #1;
        check("reset_immediate", RQ);
        repeat (4) begin
            @(clk);
            #10;
            bus.input_push_button2_d_2 = W'($urandom);
            #5;
            check("reset_hold", RQ);
        end

        // Release in the low phase: no capture until the next rising edge.
        @(negedge clk);
        #20;
        bus.input_push_button2_d_2 = '1;
        rst = 1'b0;
        #5;
        check("release_no_capture", RQ);
        edge_step('1, 1'b1, "first_capture");

        // Capture sequence 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            edge_step(caps[i], 1'b1, "capture_seq");
        end

        // Edge isolation: D falls during high phase, rises before next edge.
        #10;
        bus.input_push_button2_d_2 = '0;
        #20;
        check("edge_iso_high", model_q);
        @(negedge clk);
        #10;
        check("edge_iso_low", model_q);
        #10;
        bus.input_push_button2_d_2 = '1;
        @(posedge clk);
        model_q = '1;
        #10;
        check("edge_iso_next", model_q);

        // Low-phase activity on D must not reach Q before the edge.
        @(negedge clk);
        #5;
        for (int i = 0; i < 6; i++) begin
            bus.input_push_button2_d_2 = W'($urandom);
            #5;
            check("low_toggle", model_q);
        end
        bus.input_push_button2_d_2 = '0;
        @(posedge clk);
        model_q = '0;
        #10;
        check("low_toggle_final", model_q);

        // Randomized captures.
        for (int i = 0; i < 40; i++) begin
`ifdef DFF_MS_CLKEN_EN
            edge_step(W'($urandom), 1'($urandom_range(0, 1)), "random");
`else
            edge_step(W'($urandom), 1'b1, "random");
`endif
        end

        // Asynchronous reset 20 ns into the high phase, no clock needed.
        edge_step('1, 1'b1, "pre_reset");
        #10;
        rst = 1'b1;
        #1;
        model_q = RQ;
        check("async_reset_mid_high", RQ);
        edge_step('1, 1'b1, "reset_held");
        edge_step('1, 1'b1, "reset_held");

        // Release coinciding with a rising edge: reset wins for that edge.
        @(posedge clk);
        rst = 1'b0;
        #10;
        check("release_on_edge", RQ);
        edge_step('1, 1'b1, "after_release");

`ifdef DFF_MS_CLKEN_EN
        // Clock enable: hold with en=0, capture once en=1.
        edge_step('0, 1'b1, "en_setup");
        for (int i = 0; i < 3; i++) begin
            edge_step('1, 1'b0, "en_hold");
        end
        edge_step('1, 1'b1, "en_capture");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
